// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, legal round counts, FSM encoding and
// the byte-substitution table used by the round datapath.
package aes_pkg;

  localparam int BLK_W  = 128;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns, AddRoundKey. Byte i of the block sits at row i%4, column i/4,
// with byte 0 in the most significant position.
module AES_Round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state_i,
  input  logic [BLK_W-1:0] rkey_i,
  input  logic             final_i,
  output logic [BLK_W-1:0] state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state_i[BLK_W-1-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    // Row r rotates left by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  // The last round of the cipher skips MixColumns.
  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_o[BLK_W-1-8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ rkey_i[BLK_W-1-8*i -: 8];
  end

endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES encryption core: one round per clock through a single
// AES_Round instance. Round keys are fetched externally by index each cycle.
module aes_round_iter
  import aes_pkg::*;
#(
  parameter int NR     = NR_128,
  parameter int KIDX_W = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [BLK_W-1:0]  iData,
  output logic [KIDX_W-1:0] oKeyIdx,
  input  logic [BLK_W-1:0]  iRoundKey,
  output logic              oValid,
  input  logic              iReady,
  output logic [BLK_W-1:0]  oData,
  output logic              oBusy
);

  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
    $error("aes_round_iter: NR must be 10, 12 or 14");
  end
  if (KIDX_W < $clog2(NR + 1)) begin : g_bad_kidx
    $error("aes_round_iter: KIDX_W too narrow for NR");
  end

  localparam logic [KIDX_W-1:0] LAST_RND = KIDX_W'(NR);

  aes_state_e        state_q;
  logic [KIDX_W-1:0] rnd_q;
  logic [BLK_W-1:0]  blk_q;
  logic [BLK_W-1:0]  data_q;
  logic              valid_q;

  logic              accept;
  logic              last_rnd;
  logic [BLK_W-1:0]  round_out;
  logic [BLK_W-1:0]  blk_d;

  // Ready while idle, or when the held result is being consumed this cycle.
  // Forced high while reset is asserted so upstream never sees a stall then.
  assign oReady   = !iRst_n || (state_q == S_IDLE) || (state_q == S_DONE && iReady);
  assign accept   = iValid && oReady;
  assign last_rnd = (rnd_q == LAST_RND);
  // Initial whitening: key index is 0 whenever a block can be accepted.
  assign blk_d    = iData ^ iRoundKey;

  assign oKeyIdx  = (state_q == S_RUN) ? rnd_q : '0;
  assign oBusy    = (state_q == S_RUN);
  assign oValid   = valid_q;
  assign oData    = data_q;

  AES_Round u_round (
    .state_i (blk_q),
    .rkey_i  (iRoundKey),
    .final_i (last_rnd),
    .state_o (round_out)
  );

  // Control FSM, round counter, working state and output register.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            blk_q   <= blk_d;
            rnd_q   <= KIDX_W'(1);
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          blk_q <= round_out;
          if (last_rnd) begin
            data_q  <= round_out;
            valid_q <= 1'b1;
            rnd_q   <= '0;
            state_q <= S_DONE;
          end else begin
            rnd_q <= rnd_q + 1'b1;
          end
        end
        S_DONE: begin
          // Result held until consumed; a new block may enter on the same edge.
          if (iReady) begin
            valid_q <= 1'b0;
            if (iValid) begin
              blk_q   <= blk_d;
              rnd_q   <= KIDX_W'(1);
              state_q <= S_RUN;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_iter.sv
// Bench for aes_round_iter: three cores (AES-128/192/256) checked against
// known answers and a byte-level AES model with its own key expansion.
module tb_aes_round_iter;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]        vld_i, rdy_o, vld_o, rdy_i, busy;
  logic [2:0][127:0] din, rkey, dout;
  logic [2:0][3:0]   kidx;

  logic [127:0] ks [3][15];
  logic [7:0]   sbm [256];
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_round_iter #(.NR(10), .KIDX_W(4)) u_dut10 (
    .iClk(clk), .iRst_n(rst_n), .iValid(vld_i[0]), .oReady(rdy_o[0]), .iData(din[0]),
    .oKeyIdx(kidx[0]), .iRoundKey(rkey[0]), .oValid(vld_o[0]), .iReady(rdy_i[0]),
    .oData(dout[0]), .oBusy(busy[0]));
  aes_round_iter #(.NR(12), .KIDX_W(4)) u_dut12 (
    .iClk(clk), .iRst_n(rst_n), .iValid(vld_i[1]), .oReady(rdy_o[1]), .iData(din[1]),
    .oKeyIdx(kidx[1]), .iRoundKey(rkey[1]), .oValid(vld_o[1]), .iReady(rdy_i[1]),
    .oData(dout[1]), .oBusy(busy[1]));
  aes_round_iter #(.NR(14), .KIDX_W(4)) u_dut14 (
    .iClk(clk), .iRst_n(rst_n), .iValid(vld_i[2]), .oReady(rdy_o[2]), .iData(din[2]),
    .oKeyIdx(kidx[2]), .iRoundKey(rkey[2]), .oValid(vld_o[2]), .iReady(rdy_i[2]),
    .oData(dout[2]), .oBusy(busy[2]));

  // Round-key memories answer the requested index combinationally.
  assign rkey[0] = ks[0][kidx[0]];
  assign rkey[1] = ks[1][kidx[1]];
  assign rkey[2] = ks[2][kidx[2]];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    d = d << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] x, sq, inv;
    for (int a = 0; a < 256; a++) begin
      x = 8'(a); sq = x; inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
        sq = gmul(sq, sq);
        inv = gmul(inv, sq);
      end
      sbm[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Key expansion for instance j (Nk = 4, 6, 8); key is left-aligned.
  task automatic load_key(input int j, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = 4 + 2*j; nr = nk + 6; rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]} ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]};
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) ks[j][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_enc(input int j, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [127:0] res;
    int nr = 10 + 2*j;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[j][0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbm[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r != nr)
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) a[k] = s[4*c+k];
          for (int k = 0; k < 4; k++)
            s[4*c+k] = gmul(a[k], 8'h02) ^ gmul(a[(k+1)%4], 8'h03) ^ a[(k+2)%4] ^ a[(k+3)%4];
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[j][r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus driver ----------------
  // Offers pt to instance j, returns the result, cycles from the accept
  // cycle to the first valid cycle, and how many run cycles showed a wrong
  // key index or busy flag.
  task automatic run_block(input int j, input logic [127:0] pt,
                           output logic [127:0] ct, output int lat, output int kbad);
    int n;
    din[j] = pt; vld_i[j] = 1'b1; kbad = 0; n = 0;
    while (!rdy_o[j] && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    vld_i[j] = 1'b0;
    lat = 1;
    while (!vld_o[j] && lat < 40) begin
      if (kidx[j] !== 4'(lat) || busy[j] !== 1'b1) kbad++;
      @(posedge clk); #1; lat++;
    end
    ct = dout[j];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; vld_i = '0; rdy_i = '1; din = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (vld_o[j] !== 1'b0 || dout[j] !== '0 || busy[j] !== 1'b0 || kidx[j] !== 4'd0 || rdy_o[j] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid=%b data=%h busy=%b kidx=%0d ready=%b, expected 0 0 0 0 1",
                 j, vld_o[j], dout[j], busy[j], kidx[j], rdy_o[j]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy_o !== 3'b111) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 111", rdy_o);
    end
  endtask

  task automatic test_known_answer();
    logic [127:0] exp [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                              128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                              128'h8ea2b7ca516745bfeafc49904b496089};
    logic [127:0] ct;
    int lat, kbad;
    load_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    load_key(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    load_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    for (int j = 0; j < 3; j++) begin
      run_block(j, KAT_PT, ct, lat, kbad);
      checks++;
      if (ct !== exp[j]) begin
        errors++; $display("FAIL kat_data nr=%0d: got %h expected %h", 10+2*j, ct, exp[j]);
      end
      checks++;
      if (lat !== 11 + 2*j) begin
        errors++; $display("FAIL kat_latency nr=%0d: got %0d expected %0d", 10+2*j, lat, 11+2*j);
      end
      checks++;
      if (kbad !== 0) begin
        errors++; $display("FAIL kat_keyidx nr=%0d: %0d bad run cycles, expected 0", 10+2*j, kbad);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, ct, exp;
    int lat, kbad, j;
    for (int it = 0; it < 12; it++) begin
      j = it % 3;
      load_key(j, {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()});
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp = ref_enc(j, pt);
      run_block(j, pt, ct, lat, kbad);
      checks++;
      if (ct !== exp || lat !== 11 + 2*j || kbad !== 0) begin
        errors++;
        $display("FAIL random_block it=%0d nr=%0d: got %h lat %0d kbad %0d, expected %h lat %0d kbad 0",
                 it, 10+2*j, ct, lat, kbad, exp, 11+2*j);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, ct, exp;
    int lat, kbad, hold_bad, xfers;
    rdy_i[0] = 1'b0;
    pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = ref_enc(0, pt);
    run_block(0, pt, ct, lat, kbad);
    checks++;
    if (ct !== exp || lat !== 11) begin
      errors++; $display("FAIL bp_result: got %h lat %0d expected %h lat 11", ct, lat, exp);
    end
    din[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    vld_i[0] = 1'b1;
    hold_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (vld_o[0] !== 1'b1 || dout[0] !== exp || rdy_o[0] !== 1'b0 || busy[0] !== 1'b0) hold_bad++;
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++; $display("FAIL bp_hold: %0d unstable cycles, expected 0", hold_bad);
    end
    vld_i[0] = 1'b0; rdy_i[0] = 1'b1; #1;
    checks++;
    if (rdy_o[0] !== 1'b1) begin
      errors++; $display("FAIL bp_ready_on_consume: got %b expected 1", rdy_o[0]);
    end
    xfers = 0;
    for (int c = 0; c < 15; c++) begin
      if (vld_o[0] && rdy_i[0]) xfers++;
      @(posedge clk); #1;
    end
    checks++;
    if (xfers !== 1) begin
      errors++; $display("FAIL bp_transfers: got %0d expected 1", xfers);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, ea, eb;
    int n;
    rdy_i[0] = 1'b1;
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    ea = ref_enc(0, a); eb = ref_enc(0, b);
    din[0] = a; vld_i[0] = 1'b1; n = 0;
    while (!rdy_o[0] && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    din[0] = b;
    n = 1;
    while (!vld_o[0] && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 11 || dout[0] !== ea || rdy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: lat %0d data %h ready %b, expected lat 11 data %h ready 1", n, dout[0], rdy_o[0], ea);
    end
    @(posedge clk); #1;
    vld_i[0] = 1'b0;
    checks++;
    if (vld_o[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept: valid %b busy %b, expected 0 1", vld_o[0], busy[0]);
    end
    n = 1;
    while (!vld_o[0] && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 11 || dout[0] !== eb) begin
      errors++; $display("FAIL b2b_second: lat %0d data %h, expected lat 11 data %h", n, dout[0], eb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    logic [127:0] pt, ct, exp;
    int n, lat, kbad, pulses;
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    din[0] = pt; vld_i[0] = 1'b1; n = 0;
    while (!rdy_o[0] && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    vld_i[0] = 1'b0; n = 0;
    while (kidx[0] !== 4'd5 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (kidx[0] !== 4'd5) begin
      errors++; $display("FAIL rst_reach_round5: kidx %0d expected 5", kidx[0]);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (rdy_o[0] !== 1'b1) begin
      errors++; $display("FAIL rst_ready_during: got %b expected 1", rdy_o[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (vld_o[0] !== 1'b0 || dout[0] !== '0 || busy[0] !== 1'b0 || kidx[0] !== 4'd0 || rdy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_midrun_state: valid=%b data=%h busy=%b kidx=%0d ready=%b, expected 0 0 0 0 1",
               vld_o[0], dout[0], busy[0], kidx[0], rdy_o[0]);
    end
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (vld_o[0]) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL rst_no_valid: %0d valid cycles, expected 0", pulses);
    end
    // Reset while holding a result in DONE.
    rdy_i[0] = 1'b0;
    run_block(0, {$urandom(), $urandom(), $urandom(), $urandom()}, ct, lat, kbad);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; rdy_i[0] = 1'b1;
    checks++;
    if (vld_o[0] !== 1'b0 || dout[0] !== '0) begin
      errors++; $display("FAIL rst_in_done: valid %b data %h, expected 0 0", vld_o[0], dout[0]);
    end
    pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = ref_enc(0, pt);
    run_block(0, pt, ct, lat, kbad);
    checks++;
    if (ct !== exp || lat !== 11) begin
      errors++; $display("FAIL rst_fresh_block: got %h lat %0d expected %h lat 11", ct, lat, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_known_answer();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
